// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding unit.
package hazard_pkg;

    typedef struct packed {
        logic       valid;
        logic       wr;
        logic       ld;
        logic [4:0] rd;
    } hazard_entry_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Forward-select encoding: 0 = register file, s+1 = stage s.
    function automatic int fwd_sel_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hazard_src_match.sv
// Priority match of one decode source register against the in-flight writer chain.
module hazard_src_match
    import hazard_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int IDX_W    = 2
) (
    input  hazard_entry_t [DEPTH-1:0] entries,
    input  logic [4:0]                rs,
    input  logic                      used,
    output logic                      hit,
    output logic [IDX_W-1:0]          stageIdx,
    output logic                      ready
);

    // Scan oldest to youngest so the youngest (lowest index) match is the one that sticks.
    always_comb begin
        hit      = 1'b0;
        stageIdx = '0;
        ready    = 1'b0;
        if (used && rs != REG_ZERO) begin
            for (int s = DEPTH - 1; s >= 0; s--) begin
                if (entries[s].valid && entries[s].wr && entries[s].rd != REG_ZERO &&
                    entries[s].rd == rs) begin
                    hit      = 1'b1;
                    stageIdx = IDX_W'(s);
                    ready    = !entries[s].ld || (s >= LOAD_LAT);
                end
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Load-use hazard detection and N-stage operand forwarding beside decode.
// Optional PIPE_HAZARD_PERF_EN adds saturating stall/forward cycle counters.
module pipe_hazard_unit
    import hazard_pkg::*;
#(
    parameter int NUM_SRC  = 2,
    parameter int DEPTH    = 3,
    parameter int XLEN     = 32,
    parameter int LOAD_LAT = 1
) (
    input  logic                                         clk_i,
    input  logic                                         rst_ni,
    input  logic                                         id_valid_i,
    input  logic [NUM_SRC-1:0][4:0]                      id_rs_i,
    input  logic [NUM_SRC-1:0]                           id_rs_used_i,
    input  logic [4:0]                                   id_rd_i,
    input  logic                                         id_wr_en_i,
    input  logic                                         id_is_load_i,
    input  logic                                         flush_i,
    input  logic [NUM_SRC-1:0][XLEN-1:0]                 rf_data_i,
    input  logic [DEPTH-1:0][XLEN-1:0]                   stage_data_i,
    output logic [NUM_SRC-1:0][XLEN-1:0]                 op_data_o,
    output logic [NUM_SRC-1:0][fwd_sel_width(DEPTH)-1:0] fwd_sel_o,
    output logic                                         stall_o
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [31:0]                                  stall_cnt_o,
    output logic [31:0]                                  fwd_cnt_o
`endif
);

    localparam int SelW = fwd_sel_width(DEPTH);
    localparam int IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    hazard_entry_t [DEPTH-1:0]       chain;
    hazard_entry_t                   entryNext;
    logic [NUM_SRC-1:0]              hit;
    logic [NUM_SRC-1:0]              ready;
    logic [NUM_SRC-1:0][IdxW-1:0]    hitIdx;

    for (genvar i = 0; i < NUM_SRC; i++) begin : gSrc
        hazard_src_match #(
            .DEPTH    (DEPTH),
            .LOAD_LAT (LOAD_LAT),
            .IDX_W    (IdxW)
        ) uMatch (
            .entries  (chain),
            .rs       (id_rs_i[i]),
            .used     (id_rs_used_i[i]),
            .hit      (hit[i]),
            .stageIdx (hitIdx[i]),
            .ready    (ready[i])
        );
    end

    // A not-ready hit falls back to the register file; the stall makes the value irrelevant.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            fwd_sel_o[i] = '0;
            op_data_o[i] = rf_data_i[i];
            if (hit[i] && ready[i]) begin
                fwd_sel_o[i] = SelW'(hitIdx[i]) + SelW'(1);
                op_data_o[i] = stage_data_i[hitIdx[i]];
            end
        end
    end

    assign stall_o = id_valid_i && !flush_i && |(hit & ~ready);

    always_comb begin
        entryNext = '0;
        if (id_valid_i && !stall_o && !flush_i) begin
            entryNext.valid = 1'b1;
            entryNext.wr    = id_wr_en_i;
            entryNext.ld    = id_is_load_i;
            entryNext.rd    = id_rd_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            chain <= '0;
        end else begin
            chain[0] <= entryNext;
            for (int s = 1; s < DEPTH; s++) begin
                chain[s] <= chain[s-1];
            end
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_o <= '0;
            fwd_cnt_o   <= '0;
        end else begin
            if (stall_o && stall_cnt_o != '1) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
            if (|fwd_sel_o && fwd_cnt_o != '1) begin
                fwd_cnt_o <= fwd_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Scoreboard bench for pipe_hazard_unit: a reference chain model predicts each cycle's outputs.
module tb_pipe_hazard_unit;

    localparam int NUM_SRC  = 2;
    localparam int DEPTH    = 3;
    localparam int XLEN     = 32;
    localparam int LOAD_LAT = 1;
    localparam int SW       = 2;

    logic clk_i = 1'b0;
    logic rst_ni;
    logic id_valid_i;
    logic [NUM_SRC-1:0][4:0]      id_rs_i;
    logic [NUM_SRC-1:0]           id_rs_used_i;
    logic [4:0]                   id_rd_i;
    logic                         id_wr_en_i;
    logic                         id_is_load_i;
    logic                         flush_i;
    logic [NUM_SRC-1:0][XLEN-1:0] rf_data_i;
    logic [DEPTH-1:0][XLEN-1:0]   stage_data_i;
    logic [NUM_SRC-1:0][XLEN-1:0] op_data_o;
    logic [NUM_SRC-1:0][SW-1:0]   fwd_sel_o;
    logic                         stall_o;
`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_cnt_o;
    logic [31:0] fwd_cnt_o;
    int          mStallCnt = 0;
    int          mFwdCnt = 0;
`endif

    always #5 clk_i = ~clk_i;

    pipe_hazard_unit #(
        .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .XLEN(XLEN), .LOAD_LAT(LOAD_LAT)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .id_valid_i   (id_valid_i),
        .id_rs_i      (id_rs_i),
        .id_rs_used_i (id_rs_used_i),
        .id_rd_i      (id_rd_i),
        .id_wr_en_i   (id_wr_en_i),
        .id_is_load_i (id_is_load_i),
        .flush_i      (flush_i),
        .rf_data_i    (rf_data_i),
        .stage_data_i (stage_data_i),
        .op_data_o    (op_data_o),
        .fwd_sel_o    (fwd_sel_o),
        .stall_o      (stall_o)
`ifdef PIPE_HAZARD_PERF_EN
        ,
        .stall_cnt_o  (stall_cnt_o),
        .fwd_cnt_o    (fwd_cnt_o)
`endif
    );

    typedef struct packed {
        logic                         stall;
        logic [NUM_SRC-1:0][SW-1:0]   sel;
        logic [NUM_SRC-1:0][XLEN-1:0] data;
    } exp_t;

    exp_t  expQ[$];
    string tagQ[$];
    int    nChecks = 0;
    int    nErrors = 0;

    logic       mValid[DEPTH];
    logic       mWr[DEPTH];
    logic       mLd[DEPTH];
    logic [4:0] mRd[DEPTH];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        nChecks++;
        if (got !== want) begin
            nErrors++;
            $display("FAIL %s got=%h expected=%h", tag, got, want);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        logic anyWait;
        logic found;
        e = '0;
        anyWait = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            e.sel[i]  = '0;
            e.data[i] = rf_data_i[i];
            found = 1'b0;
            if (id_rs_used_i[i] && id_rs_i[i] != 5'd0) begin
                for (int s = 0; s < DEPTH; s++) begin
                    if (!found && mValid[s] && mWr[s] && mRd[s] != 5'd0 && mRd[s] == id_rs_i[i]) begin
                        found = 1'b1;
                        if (!mLd[s] || s >= LOAD_LAT) begin
                            e.sel[i]  = SW'(s + 1);
                            e.data[i] = stage_data_i[s];
                        end else begin
                            anyWait = 1'b1;
                        end
                    end
                end
            end
        end
        e.stall = id_valid_i && !flush_i && anyWait;
        return e;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < DEPTH; s++) begin
            mValid[s] = 1'b0; mWr[s] = 1'b0; mLd[s] = 1'b0; mRd[s] = 5'd0;
        end
`ifdef PIPE_HAZARD_PERF_EN
        mStallCnt = 0;
        mFwdCnt = 0;
`endif
    endtask

    task automatic expect_now(input string tag);
        expQ.push_back(model_out());
        tagQ.push_back(tag);
    endtask

    task automatic compare_now();
        exp_t  e;
        string t;
        e = expQ.pop_front();
        t = tagQ.pop_front();
        check_val({t, "/stall"}, 32'(stall_o), 32'(e.stall));
        for (int i = 0; i < NUM_SRC; i++) begin
            check_val($sformatf("%s/sel%0d", t, i), 32'(fwd_sel_o[i]), 32'(e.sel[i]));
            check_val($sformatf("%s/data%0d", t, i), op_data_o[i], e.data[i]);
        end
    endtask

    task automatic sample(input string tag);
        expect_now(tag);
        @(negedge clk_i);
        compare_now();
    endtask

    task automatic advance();
        exp_t e;
        e = model_out();
        @(posedge clk_i);
        if (!rst_ni) begin
            model_clear();
        end else begin
            for (int s = DEPTH - 1; s > 0; s--) begin
                mValid[s] = mValid[s-1]; mWr[s] = mWr[s-1]; mLd[s] = mLd[s-1]; mRd[s] = mRd[s-1];
            end
            mValid[0] = id_valid_i && !e.stall && !flush_i;
            mWr[0]    = mValid[0] && id_wr_en_i;
            mLd[0]    = mValid[0] && id_is_load_i;
            mRd[0]    = mValid[0] ? id_rd_i : 5'd0;
`ifdef PIPE_HAZARD_PERF_EN
            if (e.stall) mStallCnt++;
            if (|e.sel) mFwdCnt++;
`endif
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic wr, input logic ld,
                         input logic [4:0] rs0, input logic u0, input logic [4:0] rs1,
                         input logic u1, input logic fl);
        id_valid_i   = v;
        id_rd_i      = rd;
        id_wr_en_i   = wr;
        id_is_load_i = ld;
        id_rs_i      = {rs1, rs0};
        id_rs_used_i = {u1, u0};
        flush_i      = fl;
    endtask

    initial begin
        rst_ni       = 1'b0;
        rf_data_i    = {32'hAAAA_0001, 32'hAAAA_0000};
        stage_data_i = {32'h5555_0002, 32'hDEAD_BEEF, 32'h0000_0042};
        drive(1'b1, 5'd5, 1'b1, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0);
        model_clear();

        sample("reset");
`ifdef PIPE_HAZARD_PERF_EN
        check_val("reset/stall_cnt", stall_cnt_o, 32'd0);
`endif
        advance();
        rst_ni = 1'b1;

        // ALU back-to-back: add x5 then sub x6, x5, x3
        drive(1'b1, 5'd5, 1'b1, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0);
        sample("add_x5"); advance();
        drive(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd3, 1'b1, 1'b0);
        sample("sub_x5");
        check_val("alu/stall", 32'(stall_o), 32'd0);
        check_val("alu/sel0", 32'(fwd_sel_o[0]), 32'd1);
        check_val("alu/data0", op_data_o[0], 32'h0000_0042);
        advance();

        // Load-use: lw x7 then add x8, x4, x7
        drive(1'b1, 5'd7, 1'b1, 1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 1'b0);
        sample("lw_x7"); advance();
        drive(1'b1, 5'd8, 1'b1, 1'b0, 5'd4, 1'b1, 5'd7, 1'b1, 1'b0);
        sample("lu_stall");
        check_val("lu/stall_on", 32'(stall_o), 32'd1);
        advance();
        sample("lu_fwd");
        check_val("lu/stall_off", 32'(stall_o), 32'd0);
        check_val("lu/sel1", 32'(fwd_sel_o[1]), 32'd2);
        check_val("lu/data1", op_data_o[1], 32'hDEAD_BEEF);
        advance();

        // Writes to x0 are never forwarded
        drive(1'b1, 5'd0, 1'b1, 1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 1'b0);
        sample("lw_x0"); advance();
        drive(1'b1, 5'd9, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
        sample("rd_x0");
        check_val("x0/sel0", 32'(fwd_sel_o[0]), 32'd0);
        check_val("x0/data0", op_data_o[0], 32'hAAAA_0000);
        advance();

        // Double writer: x3 in EX and MEM, the EX one wins
        stage_data_i = {32'h5555_0002, 32'h0000_0022, 32'h0000_0011};
        drive(1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        sample("wr_x3_a"); advance();
        sample("wr_x3_b"); advance();
        drive(1'b1, 5'd10, 1'b1, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0);
        sample("dbl_rd");
        check_val("dbl/sel0", 32'(fwd_sel_o[0]), 32'd1);
        check_val("dbl/data0", op_data_o[0], 32'h0000_0011);
        advance();

        // Younger writer is a load still in EX: stall even though MEM holds a ready x3
        drive(1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        sample("wr_x3_c"); advance();
        drive(1'b1, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        sample("lw_x3"); advance();
        drive(1'b1, 5'd11, 1'b1, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0);
        sample("dbl_ld");
        check_val("dbl_ld/stall", 32'(stall_o), 32'd1);
        advance();
        sample("dbl_ld_fwd"); advance();

        // Flush during hazard: no stall, bubble enters EX
        stage_data_i = {32'h5555_0002, 32'hDEAD_BEEF, 32'h0000_0042};
        drive(1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        sample("lw_x7_f"); advance();
        drive(1'b1, 5'd12, 1'b1, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b1);
        sample("flush");
        check_val("flush/stall", 32'(stall_o), 32'd0);
        advance();
        drive(1'b1, 5'd13, 1'b1, 1'b0, 5'd12, 1'b1, 5'd7, 1'b1, 1'b0);
        sample("post_flush");
        check_val("flush/bubble_sel0", 32'(fwd_sel_o[0]), 32'd0);
        check_val("flush/sel1", 32'(fwd_sel_o[1]), 32'd2);
        check_val("flush/no_stall", 32'(stall_o), 32'd0);
        advance();

        // Random instruction stream against the model
        for (int n = 0; n < 300; n++) begin
            drive(($urandom_range(0, 7) != 0), 5'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
            stage_data_i = {$urandom, $urandom, $urandom};
            rf_data_i    = {$urandom, $urandom};
            sample("rand");
            advance();
        end

`ifdef PIPE_HAZARD_PERF_EN
        check_val("perf/stall_cnt", stall_cnt_o, 32'(mStallCnt));
        check_val("perf/fwd_cnt", fwd_cnt_o, 32'(mFwdCnt));
`endif

        // Reset asserted in the middle of a load-use stall
        drive(1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        sample("lw_x7_r"); advance();
        drive(1'b1, 5'd14, 1'b1, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0);
        sample("rst_pre");
        check_val("rst/pre_stall", 32'(stall_o), 32'd1);
        rst_ni = 1'b0;
        model_clear();
        #1;
        expect_now("rst_mid");
        compare_now();
        check_val("rst/stall", 32'(stall_o), 32'd0);
        check_val("rst/sel", 32'(fwd_sel_o), 32'd0);
`ifdef PIPE_HAZARD_PERF_EN
        check_val("rst/stall_cnt", stall_cnt_o, 32'd0);
`endif
        advance();
        rst_ni = 1'b1;

        // First edge after release captures decode normally
        drive(1'b1, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        sample("post_rst_add"); advance();
        drive(1'b1, 5'd15, 1'b1, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0);
        sample("post_rst_rd");
        check_val("post_rst/sel0", 32'(fwd_sel_o[0]), 32'd1);
        advance();

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Parametrised hazard-detection and operand-forwarding unit for the in-order RISC-V pipeline. It sits beside the decode stage and keeps a shadow chain of in-flight writers (rd, write-enable, load flag) for every stage after decode. It selects each decode source operand from the register file or the youngest in-flight result. It raises a load-use stall and injects a bubble when a needed result is not yet produced. It generalises fixed two-stage (MEM/WB) forwarding to any number of stages, source ports and load latency.

## Interface
- NUM_SRC, 2, source operands per instruction (1..3)
- DEPTH, 3, tracked stages after decode (index 0 = EX, DEPTH-1 = WB)
- XLEN, 32, data width
- LOAD_LAT, 1, first stage index whose stage_data_i is valid for a load (1 = MEM)
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- id_valid_i  in  1  decode holds a real instruction
- id_rs_i  in  NUM_SRC×5  source register indices
- id_rs_used_i  in  NUM_SRC  source actually read
- id_rd_i  in  5  destination register
- id_wr_en_i  in  1  instruction writes rd
- id_is_load_i  in  1  instruction is a load
- flush_i  in  1  squash decode instruction (taken branch)
- rf_data_i  in  NUM_SRC×XLEN  register-file read data
- stage_data_i  in  DEPTH×XLEN  result currently held by the instruction in stage s
- op_data_o  out  NUM_SRC×XLEN  resolved operand data
- fwd_sel_o  out  NUM_SRC×$clog2(DEPTH+1)  0 = register file, s+1 = stage s
- stall_o  out  1  freeze PC and IF/ID; bubble enters EX

## Operation
- Shadow entry per stage: valid, rd, wr, ld. A write is effective only if valid && wr && rd != 0.
- Each clock, entries s>0 take entry s-1 unconditionally, so later stages never stall.
- Entry 0 loads the decode fields when id_valid_i && !stall_o && !flush_i. Otherwise it loads a bubble (valid=0).
- For each source i with id_rs_used_i[i] && id_rs_i[i] != 0, find the lowest s with an effective write and rd == id_rs_i[i]. The youngest writer wins.
- A hit at s is ready if !ld or s >= LOAD_LAT. If ready: fwd_sel_o[i] = s+1 and op_data_o[i] = stage_data_i[s].
- A hit that is not ready raises stall_o. Older matches are never used in its place.
- No hit, rs = 0 or source unused: fwd_sel_o[i] = 0 and op_data_o[i] = rf_data_i[i].
- stall_o = id_valid_i && !flush_i && (any source not ready). flush_i has priority over a stall.
- The writeback-to-decode same-cycle case is covered by stage DEPTH-1 forwarding; no register-file write-through is needed.

## Timing
- Outputs are combinational from the shadow chain and decode inputs, with zero-cycle latency.
- The shadow chain updates on posedge clk_i.
- A load-use stall lasts LOAD_LAT − s cycles for a hit at s. With the defaults, a load in EX stalls for exactly 1 cycle, and the next cycle forwards from MEM (fwd_sel = 2).
- Reset (asynchronous, any cycle including mid-stall): all entries invalid, stall_o = 0, fwd_sel_o = 0, op_data_o = rf_data_i.
- First edge after reset release: entry 0 captures decode normally.
- Simultaneous flush_i and hazard: stall_o = 0 and a bubble enters EX.
- Two writers to the same rd: the lower stage index is selected even if a higher one is ready. Stall if the lower one is not ready.

## Configuration
- PIPE_HAZARD_PERF_EN defined: adds stall_cnt_o and fwd_cnt_o (32 bits each, out).
  - stall_cnt_o counts cycles with stall_o = 1.
  - fwd_cnt_o counts cycles with any fwd_sel_o != 0.
  - Both counters saturate at all-ones and reset to 0 asynchronously.
- PIPE_HAZARD_PERF_EN undefined: these ports and counters do not exist.

## Structure
- Package hazard_pkg holds:
  - the typedef struct packed hazard_entry_t {valid, wr, ld, rd[4:0]}
  - constant REG_ZERO = 5'd0
  - function fwd_sel_width(depth)
- Sub-module hazard_src_match (one instance per source) does the priority match across DEPTH entries. It outputs hit, stage index and ready.
- The top level holds the shadow chain, the stall OR-reduction, the operand muxes and the optional counters.

## Test plan
- ALU back-to-back: add x5 then sub reading x5 → no stall. fwd_sel[0] = 1 and op_data = stage_data_i[0] = 0x0000_0042.
- Load-use: lw x7 then add rs2 = x7 → stall_o = 1 for exactly one cycle, then fwd_sel[1] = 2 with op_data = load value 0xDEAD_BEEF.
- Writes to x0: lw x0 followed by a reader of x0 → no stall, fwd_sel = 0, op_data = rf_data_i.
- Double writer: x3 written in EX (0x11) and MEM (0x22) → op_data = 0x11, fwd_sel = 1.
- Flush during hazard: load-use pair with flush_i = 1 → stall_o = 0 and next entry 0 invalid. A following reader of x7 forwards from MEM without stalling.
- Reset mid-stall: assert rst_ni = 0 while stall_o = 1 → stall_o drops immediately and all fwd_sel = 0. With PIPE_HAZARD_PERF_EN, stall_cnt_o = 0.
